// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Sequencing controller for the five-stage pipeline. Drives the
//             enable/flush pair of the PC and the IF/ID, ID/EX, EX/MEM and
//             MEM/WB registers. Resolves memory wait states, multi-cycle EX
//             operations, load-use hazards and taken-branch redirects in a
//             fixed priority order.
//  Options  : PIPE_CTRL_PERF_EN - keep saturating stall/flush counters;
//             when undefined both counter outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_is_load_i,
    input  logic                  ex_is_mc_i,
    input  logic                  ex_redirect_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ready_i,
    input  logic                  mc_done_i,
    output logic                  mc_start_o,
    output logic                  pc_en_o,
    output logic                  ifid_en_o,
    output logic                  idex_en_o,
    output logic                  exmem_en_o,
    output logic                  memwb_en_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic                  exmem_flush_o,
    output logic                  memwb_flush_o,
    output logic                  redirect_take_o,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      flush_events_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic w_mem_stall;
    logic w_load_use;
    logic w_mc_hold;

    assign w_mem_stall = mem_req_i & ~mem_ready_i;

    assign w_load_use = ex_is_load_i && (ex_rd_i != '0) &&
                        ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                         (id_rs2_used_i && (id_rs2_i == ex_rd_i)));

    // The multi-cycle result is held back in MC_DONE until MEM can move,
    // so EX/MEM captures it on the same edge the pipeline resumes.
    assign w_mc_hold = ((state_q == RUN)     &  ex_is_mc_i) |
                       ((state_q == MC_BUSY) & ~mc_done_i)  |
                       ((state_q == MC_DONE) &  w_mem_stall);

    // Multi-cycle handshake state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, start pulse and prioritised pipeline controls.
    always_comb begin
        state_d         = state_q;
        mc_start_o      = 1'b0;
        pc_en_o         = 1'b0;
        ifid_en_o       = 1'b0;
        idex_en_o       = 1'b0;
        exmem_en_o      = 1'b0;
        memwb_en_o      = 1'b0;
        ifid_flush_o    = 1'b0;
        idex_flush_o    = 1'b0;
        exmem_flush_o   = 1'b0;
        memwb_flush_o   = 1'b0;
        redirect_take_o = 1'b0;

        if (rst) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    // Start is deferred while MEM stalls so it fires once.
                    if (ex_is_mc_i && !w_mem_stall) begin
                        mc_start_o = 1'b1;
                        state_d    = MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    if (mc_done_i) begin
                        state_d = w_mem_stall ? MC_DONE : RUN;
                    end
                end
                MC_DONE: begin
                    if (!w_mem_stall) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase

            if (w_mem_stall) begin
                memwb_en_o    = 1'b1;
                memwb_flush_o = 1'b1;
            end else if (w_mc_hold) begin
                exmem_en_o    = 1'b1;
                exmem_flush_o = 1'b1;
                memwb_en_o    = 1'b1;
            end else if (ex_redirect_i) begin
                // ID and IF hold wrong-path instructions; redirect wins
                // over a simultaneous load-use hazard.
                pc_en_o         = 1'b1;
                ifid_en_o       = 1'b1;
                idex_en_o       = 1'b1;
                exmem_en_o      = 1'b1;
                memwb_en_o      = 1'b1;
                ifid_flush_o    = 1'b1;
                idex_flush_o    = 1'b1;
                redirect_take_o = 1'b1;
            end else if (w_load_use) begin
                idex_en_o    = 1'b1;
                idex_flush_o = 1'b1;
                exmem_en_o   = 1'b1;
                memwb_en_o   = 1'b1;
            end else begin
                pc_en_o    = 1'b1;
                ifid_en_o  = 1'b1;
                idex_en_o  = 1'b1;
                exmem_en_o = 1'b1;
                memwb_en_o = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Saturating counters of frozen-PC cycles and taken redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en_o && (stall_q != '1)) begin
                stall_q <= stall_q + c_one;
            end
            if (redirect_take_o && (flush_q != '1)) begin
                flush_q <= flush_q + c_one;
            end
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_events_o = flush_q;
`else
    assign stall_cycles_o = '0;
    assign flush_events_o = '0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central sequencing controller for the five-stage pipeline: it drives the enable and flush inputs of the PC register and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB), all built from the team's enable/flush pipeline register.
- Resolves data-memory wait states, multi-cycle EX operations (mul/div), load-use hazards and taken-branch redirects with a fixed priority.
- Runs a small FSM for the multi-cycle unit handshake.
- Optionally keeps performance counters.

## Interface
- REG_ADDR_W, default 5: register-file address width.
- CNT_W, default 32: performance counter width.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_rs1, id_rs2  in  REG_ADDR_W  source register addresses of the instruction in ID
- id_rs1_used, id_rs2_used  in  1  the ID instruction reads that source
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction
- ex_is_load  in  1  EX instruction is a load
- ex_is_mc  in  1  EX instruction needs the multi-cycle unit
- ex_redirect  in  1  EX resolved a taken branch/jump (mispredict)
- mem_req, mem_ready  in  1  data-memory request from MEM and its ready
- mc_done  in  1  multi-cycle result valid (level; the unit holds it until the next mc_start)
- mc_start  out  1  single-cycle start pulse to the multi-cycle unit
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  register flushes
- redirect_take  out  1  PC loads the branch target this cycle
- stall_cycles, flush_events  out  CNT_W  performance counters

## Operation
Definitions:
- mem_stall = mem_req & ~mem_ready
- load_use = ex_is_load & ex_rd≠0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd))
- mc_hold = (state==RUN & ex_is_mc) | (state==MC_BUSY & ~mc_done) | (state==MC_DONE & mem_stall)

Controls are combinational from inputs and state. The first matching priority applies:
1. **mem_stall**
   - pc/ifid/idex/exmem_en=0.
   - memwb_en=1, memwb_flush=1 (bubble into WB).
   - All other flushes=0, redirect_take=0.
2. **mc_hold**
   - pc/ifid/idex_en=0.
   - exmem_en=1, exmem_flush=1, memwb_en=1.
   - redirect_take=0.
3. **ex_redirect**
   - All en=1, ifid_flush=idex_flush=1, redirect_take=1.
4. **load_use**
   - pc_en=ifid_en=0.
   - idex_en=1, idex_flush=1.
   - exmem_en=memwb_en=1.
5. **Default**
   - All en=1, all flushes=0.

FSM states: RUN, MC_BUSY, MC_DONE.
- **RUN**: on ex_is_mc & ~mem_stall → mc_start=1, go to MC_BUSY. mc_done is ignored in RUN.
- **MC_BUSY**:
  - mc_done & ~mem_stall → release (priority 2 drops) and go to RUN.
  - mc_done & mem_stall → MC_DONE.
  - Otherwise stay.
- **MC_DONE**: ~mem_stall → release and go to RUN.

Other rules:
- ex_redirect is held by the frozen EX stage, so it is taken only after stalls clear.
- A redirect is never lost or taken twice.
- A redirect together with a load-use hazard takes the redirect; the ID instruction is on the wrong path.
- mc_start fires exactly once per multi-cycle instruction.
- While rst is high:
  - All en=0, all flushes=0, mc_start=0, redirect_take=0.
  - Next state is RUN; counters clear to 0.
  - Reset in MC_BUSY abandons the operation.

## Timing
- Zero-latency control: outputs respond in the same cycle as the inputs.
- The state register and counters update on the rising edge of clk.
- Minimum penalties:
  - load-use: 1 bubble.
  - redirect: 2 flushed slots.
  - multi-cycle op: N+1 cycles when mc_done arrives N cycles after mc_start.
- mc_start is asserted in the first cycle of mc_hold only.
- Release occurs in the cycle where mc_done (or the end of mem_stall in MC_DONE) is seen; EX/MEM captures the result at that edge.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles increments each non-reset cycle with pc_en=0.
  - flush_events increments each cycle with redirect_take=1.
  - Both saturate at all-ones.
- Undefined: no counter registers; both outputs are constant 0.

## Test plan
- Load x5 in EX, ID reads rs2=x5 (used) → one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle all en=1. Repeat with ex_rd=0 → no stall.
- ex_redirect=1 with no stalls → ifid_flush=idex_flush=1, redirect_take=1 for exactly one cycle; flush_events +1 (macro on).
- ex_is_mc=1, mc_done arrives 4 cycles after mc_start → mc_start pulses once, exmem_flush=1 for 4 cycles, release on the 5th cycle, state returns to RUN.
- mc_done while mem_req=1, mem_ready=0 for 3 cycles → FSM goes to MC_DONE; memwb_flush=1 for 3 cycles; release the cycle mem_ready rises; no second mc_start.
- ex_redirect held during a 2-cycle mem_stall → redirect_take=0 for 2 cycles, then 1 for exactly one cycle.
- rst asserted in MC_BUSY → all en=0, counters 0; after rst falls, state is RUN and a pending ex_is_mc produces a new mc_start.
